// File: rtl/senseye_pkg.sv
// Shared definitions for the SensEye camera capture blocks: AHB register
// offsets, STATUS/CTRL bit positions and HTRANS encodings.
package senseye_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_addr_e;

  localparam int unsigned STATUS_OVF_BIT   = 18;
  localparam int unsigned STATUS_FULL_BIT  = 17;
  localparam int unsigned STATUS_EMPTY_BIT = 16;

  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned CTRL_FLUSH_BIT  = 1;
  localparam int unsigned CTRL_ENABLE_BIT = 0;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/senseye_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level tracking and flush.
// Flush dominates push/pop; a push while full succeeds only alongside a pop.
module senseye_sync_fifo #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned LVL_W  = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = mem[rd_ptr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ahb_pixel_fifo.sv
// AHB-Lite slave that packs an 8-bit camera pixel stream into 32-bit words,
// buffers them in a FIFO and exposes DATA/STATUS/CTRL/THRESH registers.
module ahb_pixel_fifo
  import senseye_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned LVL_W = 10
) (
  input  logic        SYSCLK,
  input  logic        SYSRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic        PIX_VALID,
  input  logic [7:0]  PIX_DATA,
  input  logic        FRAME_START,
  output logic        IRQ
);

  logic             dp_valid;
  logic             dp_write;
  reg_addr_e        dp_addr;
  logic             dp_rd;
  logic             dp_wr;

  logic             enable;
  logic             irq_en;
  logic [LVL_W-1:0] thresh;
  logic             overflow;
  logic             irq_q;

  logic [1:0]       pix_idx;
  logic [23:0]      pix_word;
  logic             push_req;
  logic [31:0]      push_word;

  logic [31:0]      head;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             pop;
  logic             flush;
  logic             ovf_event;

  logic             unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = irq_q;

  // A reset landing on a data phase aborts it: no pop, no register write.
  assign dp_rd     = dp_valid & ~dp_write & ~SYSRESET;
  assign dp_wr     = dp_valid &  dp_write & ~SYSRESET;
  assign pop       = dp_rd & (dp_addr == REG_DATA) & ~empty;
  assign flush     = dp_wr & (dp_addr == REG_CTRL) & HWDATA[CTRL_FLUSH_BIT];
  assign ovf_event = push_req & full & ~pop & ~flush;

  senseye_sync_fifo #(
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W),
    .DATA_W (32)
  ) u_fifo (
    .clk   (SYSCLK),
    .rst   (SYSRESET),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .wdata (push_word),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Address phase capture for the following data phase.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= REG_DATA;
    end else begin
      dp_valid <= HSEL & htrans_active(HTRANS) & HREADYIN;
      dp_write <= HWRITE;
      dp_addr  <= reg_addr_e'(HADDR[3:2]);
    end
  end

  // Control registers and sticky overflow; a new overflow beats its W1C clear.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= '0;
      overflow <= 1'b0;
    end else begin
      if (dp_wr && dp_addr == REG_CTRL) begin
        enable <= HWDATA[CTRL_ENABLE_BIT];
        irq_en <= HWDATA[CTRL_IRQ_EN_BIT];
      end
      if (dp_wr && dp_addr == REG_THRESH) begin
        thresh <= HWDATA[LVL_W-1:0];
      end
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (dp_wr && dp_addr == REG_STATUS && HWDATA[STATUS_OVF_BIT]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Pixel packer: bytes fill bits [7:0] first; a full word is pushed one cycle later.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET || flush) begin
      pix_idx   <= '0;
      pix_word  <= '0;
      push_req  <= 1'b0;
      push_word <= '0;
    end else begin
      push_req <= 1'b0;
      if (FRAME_START) begin
        pix_idx  <= '0;
        pix_word <= '0;
        if (enable && PIX_VALID) begin
          pix_word[7:0] <= PIX_DATA;
          pix_idx       <= 2'd1;
        end
      end else if (enable && PIX_VALID) begin
        if (pix_idx == 2'd3) begin
          push_req  <= 1'b1;
          push_word <= {PIX_DATA, pix_word};
          pix_idx   <= '0;
        end else begin
          pix_word[{pix_idx, 3'b000} +: 8] <= PIX_DATA;
          pix_idx                          <= pix_idx + 2'd1;
        end
      end
    end
  end

  // Registered interrupt, lagging level/overflow changes by one cycle.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en & (((level >= thresh) & (thresh != '0)) | overflow);
    end
  end

  // Data-phase read mux; DATA returns the FIFO head, or zero when empty.
  always_comb begin
    HRDATA = '0;
    if (dp_rd) begin
      case (dp_addr)
        REG_DATA: HRDATA = empty ? '0 : head;
        REG_STATUS: begin
          HRDATA[STATUS_OVF_BIT]   = overflow;
          HRDATA[STATUS_FULL_BIT]  = full;
          HRDATA[STATUS_EMPTY_BIT] = empty;
          HRDATA[LVL_W-1:0]        = level;
        end
        REG_CTRL: begin
          HRDATA[CTRL_IRQ_EN_BIT] = irq_en;
          HRDATA[CTRL_ENABLE_BIT] = enable;
        end
        REG_THRESH: HRDATA[LVL_W-1:0] = thresh;
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_pixel_fifo.sv
// Directed plus randomized bench for ahb_pixel_fifo, checked against a
// queue-based model of the packer, FIFO and register map.
module tb_ahb_pixel_fifo;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LVL_W = 10;

  logic        SYSCLK = 1'b0;
  logic        SYSRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        PIX_VALID;
  logic [7:0]  PIX_DATA;
  logic        FRAME_START;
  logic        IRQ;

  ahb_pixel_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .SYSCLK      (SYSCLK),
    .SYSRESET    (SYSRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HREADYIN    (HREADYIN),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .PIX_VALID   (PIX_VALID),
    .PIX_DATA    (PIX_DATA),
    .FRAME_START (FRAME_START),
    .IRQ         (IRQ)
  );

  always #5 SYSCLK = ~SYSCLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  logic [31:0] q[$];
  logic [7:0]  pb[$];
  bit          m_en;
  bit          m_irq_en;
  bit          m_ovf;
  int unsigned m_thresh;

  logic [31:0] rd_buf [DEPTH+8];

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[18] = m_ovf;
    s[17] = (q.size() == DEPTH);
    s[16] = (q.size() == 0);
    s[LVL_W-1:0] = LVL_W'(q.size());
    return s;
  endfunction

  function automatic logic exp_irq();
    return m_irq_en && ((q.size() >= m_thresh && m_thresh != 0) || m_ovf);
  endfunction

  function automatic void m_pixel(input logic [7:0] b);
    if (m_en) begin
      pb.push_back(b);
      if (pb.size() == 4) begin
        if (q.size() < DEPTH) q.push_back({pb[3], pb[2], pb[1], pb[0]});
        else m_ovf = 1'b1;
        pb.delete();
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    PIX_VALID = 1'b1;
    PIX_DATA  = b;
    m_pixel(b);
    @(negedge SYSCLK);
    PIX_VALID = 1'b0;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  task automatic frame_start(input logic v, input logic [7:0] b);
    FRAME_START = 1'b1;
    PIX_VALID   = v;
    PIX_DATA    = b;
    pb.delete();
    if (v && m_en) pb.push_back(b);
    @(negedge SYSCLK);
    FRAME_START = 1'b0;
    PIX_VALID   = 1'b0;
  endtask

  // Pipelined read burst: address of beat i+1 overlaps data phase of beat i.
  task automatic ahb_read(input int n, input logic [1:0] a);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) rd_buf[i-1] = HRDATA;
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      @(negedge SYSCLK);
    end
  endtask

  task automatic ahb_write(input logic [1:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
    @(negedge SYSCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge SYSCLK);
  endtask

  task automatic check_status(input string tag);
    ahb_read(1, 2'd1);
    chk(tag, rd_buf[0], exp_status());
  endtask

  task automatic read_data_check(input int n, input string tag);
    logic [31:0] e;
    ahb_read(n, 2'd0);
    for (int i = 0; i < n; i++) begin
      e = (q.size() > 0) ? q.pop_front() : 32'h0;
      chk(tag, rd_buf[i], e);
    end
  endtask

  task automatic check_irq(input string tag);
    repeat (2) @(negedge SYSCLK);
    chk(tag, {31'h0, IRQ}, {31'h0, exp_irq()});
  endtask

  task automatic write_ctrl(input logic ie, input logic fl, input logic en);
    ahb_write(2'd2, {29'h0, ie, fl, en});
    m_irq_en = ie;
    m_en     = en;
    if (fl) begin
      q.delete();
      pb.delete();
    end
  endtask

  initial begin
    logic [7:0] b;
    int unsigned op;

    SYSRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = '0; HREADYIN = 1'b1; PIX_VALID = 1'b0;
    PIX_DATA = '0; FRAME_START = 1'b0;
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_thresh = 0;
    repeat (3) @(negedge SYSCLK);
    SYSRESET = 1'b0;

    // Reset state.
    chk("reset_irq", {31'h0, IRQ}, 32'h0);
    chk("reset_hrdata", HRDATA, 32'h0);
    chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("hresp", {31'h0, HRESP}, 32'h0);
    ahb_read(1, 2'd1);
    chk("reset_status", rd_buf[0], 32'h0001_0000);
    ahb_read(1, 2'd2);
    chk("reset_ctrl", rd_buf[0], 32'h0);

    // Basic packing order.
    write_ctrl(1'b0, 1'b0, 1'b1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check_status("pack_status_l1");
    ahb_read(1, 2'd0);
    chk("pack_word", rd_buf[0], 32'h4433_2211);
    void'(q.pop_front());
    check_status("pack_status_l0");

    // Frame start discards partial word and takes the concurrent pixel as byte0.
    send_byte(8'hAA); send_byte(8'hBB);
    frame_start(1'b1, 8'h01);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check_status("frame_status");
    ahb_read(1, 2'd0);
    chk("frame_word", rd_buf[0], 32'h0403_0201);
    void'(q.pop_front());

    // Fill past full: overflow, W1C, then drain in order and read empty.
    for (int w = 0; w < DEPTH + 1; w++) send_pixels(4);
    ahb_read(1, 2'd1);
    chk("full_status", rd_buf[0], 32'h0006_0200);
    ahb_write(2'd1, 32'h0004_0000);
    m_ovf = 1'b0;
    check_status("ovf_cleared");
    read_data_check(DEPTH + 1, "drain");
    check_status("drained");

    // Threshold interrupt timing.
    ahb_write(2'd3, 32'd2);
    m_thresh = 2;
    write_ctrl(1'b1, 1'b0, 1'b1);
    send_pixels(4);
    send_pixels(3);
    send_byte(8'h5A);
    chk("irq_before", {31'h0, IRQ}, 32'h0);
    @(negedge SYSCLK);
    chk("irq_lag", {31'h0, IRQ}, 32'h0);
    @(negedge SYSCLK);
    chk("irq_set", {31'h0, IRQ}, 32'h1);
    read_data_check(1, "irq_read");
    @(negedge SYSCLK);
    chk("irq_clear", {31'h0, IRQ}, 32'h0);

    // Pop coinciding with a push at level 3.
    send_pixels(8);
    send_pixels(3);
    check_status("l3_status");
    b = 8'($urandom);
    PIX_VALID = 1'b1; PIX_DATA = b;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
    @(negedge SYSCLK);
    PIX_VALID = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
    chk("coincide_rd", HRDATA, q.pop_front());
    m_pixel(b);
    @(negedge SYSCLK);
    check_status("coincide_level");
    read_data_check(4, "coincide_drain");

    // Flush empties FIFO and packer; flush bit reads back 0.
    send_pixels(10);
    write_ctrl(1'b1, 1'b1, 1'b1);
    check_status("flush_status");
    read_data_check(1, "flush_empty_rd");
    ahb_read(1, 2'd2);
    chk("ctrl_readback", rd_buf[0], 32'h5);
    send_pixels(4);
    read_data_check(1, "post_flush_word");

    // Randomized traffic.
    m_thresh = $urandom_range(0, 6);
    ahb_write(2'd3, 32'(m_thresh));
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: send_pixels($urandom_range(1, 9));
        1: read_data_check($urandom_range(1, 3), "rand_data");
        2: if (m_en) frame_start(1'($urandom), 8'($urandom));
        3: write_ctrl(1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        default: begin
          check_status("rand_status");
          check_irq("rand_irq");
        end
      endcase
    end
    check_status("final_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
